// File: rtl/ram_boot_loader_pkg.sv
// Shared types and helpers for the RAM boot loader: FSM state encoding and
// lane-count to byte-enable conversion.
package ram_boot_loader_pkg;

  localparam int unsigned BeMaskWidth = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DRAIN,
    DONE
  } state_e;

  // Number of filled lanes (0..4) -> contiguous low-order byte-enable mask.
  function automatic logic [BeMaskWidth-1:0] be_from_lanes(input logic [2:0] lanes);
    logic [BeMaskWidth-1:0] be;
    case (lanes)
      3'd0:    be = 4'b0000;
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ram_boot_loader_packer.sv
// Little-endian byte packer: each pushed byte lands in the next free lane of a
// 32-bit word; the lane count drives the byte-enable mask.
module ram_boot_loader_packer
  import ram_boot_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [7:0]             i_byte,
  output logic [31:0]            o_word,
  output logic [BeMaskWidth-1:0] o_be,
  output logic                   o_last_lane
);

  logic [2:0]  r_count;
  logic [31:0] r_word;

  // Clear wins over push; the top never does both in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_push) begin
      r_word[{r_count[1:0], 3'b000} +: 8] <= i_byte;
      r_count                             <= r_count + 3'd1;
    end
  end

  assign o_word      = r_word;
  assign o_be        = be_from_lanes(r_count);
  assign o_last_lane = (r_count == 3'd3);

endmodule

// File: rtl/ram_boot_loader.sv
// Streams host bytes into RAM as packed words from a base address, reads the
// region back into an additive checksum, and releases core reset after a load.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int unsigned AddrWidth = 14,
  parameter int unsigned LenWidth  = 16,
  parameter bit          BootHold  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_bytes_i,
  input  logic                 s_valid_i,
  input  logic [7:0]           s_data_i,
  output logic                 s_ready_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [3:0]           be_o,
  output logic [31:0]          addr_o,
  output logic [31:0]          wdata_o,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          checksum_o,
  output logic                 core_rst_no
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [AddrWidth-1:0]   r_base;
  logic [AddrWidth-1:0]   r_addr;
  logic [AddrWidth-1:0]   r_rd_left;
  logic [LenWidth-1:0]    r_bytes_left;
  logic [BeMaskWidth-1:0] r_last_be;
  logic [31:0]            r_checksum;
  logic                   r_core_rst_n;
  logic                   r_rd_pend;

  logic                   w_accept;
  logic                   w_pack_clear;
  logic [31:0]            w_word;
  logic [BeMaskWidth-1:0] w_pack_be;
  logic                   w_last_lane;
  logic [BeMaskWidth-1:0] w_rd_be;
  logic [31:0]            w_rd_mask;

  assign w_accept     = s_valid_i & s_ready_o;
  assign w_pack_clear = ((r_state == IDLE) & start_i) | (r_state == WRITE);

  ram_boot_loader_packer u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_clear     (w_pack_clear),
    .i_push      (w_accept),
    .i_byte      (s_data_i),
    .o_word      (w_word),
    .o_be        (w_pack_be),
    .o_last_lane (w_last_lane)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (start_i) w_state_next = (len_bytes_i == '0) ? DONE : LOAD;
      LOAD:  if (w_accept && (w_last_lane || (r_bytes_left == LenWidth'(1))))
               w_state_next = WRITE;
      WRITE: w_state_next = (r_bytes_left == '0) ? CHECK : LOAD;
      CHECK: if (r_rd_left == '0) w_state_next = DRAIN;
      DRAIN: w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Only the last read can return in DRAIN, so that is where the partial mask applies.
  always_comb begin
    w_rd_be = (r_state == DRAIN) ? r_last_be : '1;
    for (int unsigned b = 0; b < BeMaskWidth; b++) begin
      w_rd_mask[8*b +: 8] = {8{w_rd_be[b]}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_addr       <= '0;
      r_rd_left    <= '0;
      r_bytes_left <= '0;
      r_last_be    <= '0;
      r_checksum   <= '0;
      r_core_rst_n <= !BootHold;
      r_rd_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rd_pend <= req_o & ~we_o;
      case (r_state)
        IDLE: if (start_i) begin
          r_base       <= base_addr_i;
          r_addr       <= base_addr_i;
          r_bytes_left <= len_bytes_i;
          r_rd_left    <= AddrWidth'((len_bytes_i - LenWidth'(1)) >> 2);
          r_last_be    <= be_from_lanes((len_bytes_i[1:0] == 2'd0) ? 3'd4
                                                                   : {1'b0, len_bytes_i[1:0]});
          r_checksum   <= '0;
        end
        LOAD:  if (w_accept) r_bytes_left <= r_bytes_left - LenWidth'(1);
        WRITE: r_addr <= (r_bytes_left == '0) ? r_base : r_addr + AddrWidth'(1);
        CHECK: begin
          r_addr    <= r_addr + AddrWidth'(1);
          r_rd_left <= r_rd_left - AddrWidth'(1);
        end
        DONE:  r_core_rst_n <= 1'b1;
        default: ;
      endcase
      if (rvalid_i && ((r_state == CHECK) || (r_state == DRAIN))) begin
        r_checksum <= r_checksum + (rdata_i & w_rd_mask);
      end
    end
  end

  assign s_ready_o   = (r_state == LOAD);
  assign req_o       = (r_state == WRITE) || (r_state == CHECK);
  assign we_o        = (r_state == WRITE);
  assign be_o        = (r_state == WRITE) ? w_pack_be : ((r_state == CHECK) ? 4'hF : 4'h0);
  assign addr_o      = req_o ? 32'(r_addr) : '0;
  assign wdata_o     = we_o ? w_word : '0;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign checksum_o  = r_checksum;
  assign core_rst_no = r_core_rst_n;

  ap_req_single_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_o |-> $onehot({r_state == WRITE, r_state == CHECK}));

  ap_rvalid_after_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> r_rd_pend);

endmodule

// File: tb/tb_ram_boot_loader.sv
// Self-checking bench for ram_boot_loader: a RAM model responds to the DUT and a
// byte-level reference model predicts writes, read order and checksum.
module tb_ram_boot_loader;

  localparam int unsigned AW       = 14;
  localparam int unsigned MemWords = 1 << AW;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [15:0]   len_bytes_i = '0;
  logic          s_valid_i = 1'b0;
  logic [7:0]    s_data_i = '0;
  logic          s_ready_o;
  logic          req_o;
  logic          we_o;
  logic [3:0]    be_o;
  logic [31:0]   addr_o;
  logic [31:0]   wdata_o;
  logic          rvalid_i;
  logic [31:0]   rdata_i;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   checksum_o;
  logic          core_rst_no;

  int unsigned tests = 0;
  int unsigned failed = 0;

  logic [31:0] ram     [MemWords];
  logic [31:0] ref_mem [MemWords];
  logic [7:0]  byte_q [$];
  wr_t         wr_log [$];
  wr_t         exp_wr [$];
  int unsigned rd_log [$];
  int unsigned req_cnt, done_cnt, wr_rdy_viol, rd_be_bad;

  always #5 clk_i = ~clk_i;

  ram_boot_loader #(.AddrWidth(AW), .LenWidth(16), .BootHold(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_bytes_i(len_bytes_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .busy_o(busy_o),
    .done_o(done_o), .checksum_o(checksum_o), .core_rst_no(core_rst_no)
  );

  // RAM: byte-enabled writes, 1-cycle read latency; rdata is junk when not reading.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_i <= 1'b0;
      rdata_i  <= '0;
    end else begin
      rvalid_i <= req_o && !we_o;
      rdata_i  <= (req_o && !we_o) ? ram[addr_o[AW-1:0]] : $urandom;
      if (req_o && we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (be_o[b]) ram[addr_o[AW-1:0]][8*b +: 8] <= wdata_o[8*b +: 8];
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_o) req_cnt++;
      if (done_o) done_cnt++;
      if (we_o && s_ready_o) wr_rdy_viol++;
      if (req_o && !we_o && be_o !== 4'hF) rd_be_bad++;
      if (req_o && we_o) wr_log.push_back('{addr_o, wdata_o, be_o});
      if (req_o && !we_o) rd_log.push_back(addr_o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang required $finish");
    $fatal(1);
  end

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = be[j] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Reference: byte i goes to word (base + i/4) mod 2**AW, lane i%4; then sum read-back.
  function automatic logic [31:0] build_model(input int unsigned base, input int unsigned len);
    logic [31:0] sum;
    int unsigned nw, n;
    wr_t w;
    sum = '0;
    nw  = (len + 3) / 4;
    exp_wr.delete();
    for (int unsigned k = 0; k < nw; k++) begin
      n      = (len - 4*k >= 4) ? 4 : len - 4*k;
      w.addr = (base + k) % MemWords;
      w.data = '0;
      w.be   = 4'((1 << n) - 1);
      for (int unsigned j = 0; j < n; j++) begin
        w.data[8*j +: 8]         = byte_q[4*k + j];
        ref_mem[w.addr][8*j +: 8] = byte_q[4*k + j];
      end
      exp_wr.push_back(w);
    end
    for (int unsigned k = 0; k < nw; k++) begin
      sum += ref_mem[exp_wr[k].addr] & be_mask(exp_wr[k].be);
    end
    return sum;
  endfunction

  function automatic int unsigned wr_mismatches();
    int unsigned bad, n;
    bad = 0;
    n   = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int unsigned i = 0; i < n; i++) begin
      if (wr_log[i].addr != exp_wr[i].addr || wr_log[i].be != exp_wr[i].be ||
          (wr_log[i].data & be_mask(exp_wr[i].be)) != exp_wr[i].data) bad++;
    end
    return bad;
  endfunction

  function automatic int unsigned rd_mismatches();
    int unsigned bad;
    bad = (rd_log.size() != exp_wr.size()) ? 1 : 0;
    for (int unsigned i = 0; i < rd_log.size() && i < exp_wr.size(); i++) begin
      if (rd_log[i] != exp_wr[i].addr) bad++;
    end
    return bad;
  endfunction

  function automatic void fill_bytes(input int unsigned len);
    byte_q.delete();
    for (int unsigned i = 0; i < len; i++) byte_q.push_back(8'($urandom));
  endfunction

  // lat = clock edges from the edge that samples start_i to the first done_o cycle.
  task automatic run_load(input int unsigned base, input int unsigned len, input bit rnd,
                          input bit abuse, output int unsigned lat);
    int unsigned idx, cyc;
    bit acc, seen;
    idx = 0; cyc = 0; seen = 1'b0; lat = 0;
    @(negedge clk_i);
    wr_log.delete(); rd_log.delete();
    req_cnt = 0; done_cnt = 0; wr_rdy_viol = 0; rd_be_bad = 0;
    base_addr_i = AW'(base);
    len_bytes_i = 16'(len);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (!seen && cyc < 200 + 12*len) begin
      if (done_o) begin
        seen    = 1'b1;
        lat     = cyc + 1;
        start_i = 1'b0;
      end else begin
        s_valid_i = (idx < len) && (!rnd || $urandom_range(0, 1) == 1);
        s_data_i  = (idx < len) ? byte_q[idx] : 8'($urandom);
        if (abuse && $urandom_range(0, 5) == 0) begin
          start_i     = 1'b1;
          base_addr_i = AW'($urandom);
          len_bytes_i = 16'($urandom);
        end else begin
          start_i = 1'b0;
        end
        acc = s_valid_i && s_ready_o;
        @(negedge clk_i);
        if (acc) idx++;
        cyc++;
      end
    end
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL done_timeout: got no done_o after %0d cycles, required done (base %0h len %0d)",
               cyc, base, len);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({s_ready_o, req_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o, checksum_o} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got ready=%b req=%b we=%b be=%h addr=%h wdata=%h busy=%b done=%b sum=%h, required all 0",
               s_ready_o, req_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o, checksum_o);
    end
    tests++;
    if (core_rst_no !== 1'b0) begin
      failed++;
      $display("FAIL reset_core_rst: got %b required 0", core_rst_no);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_load();
    int unsigned got, cyc, lat;
    logic [31:0] exp_sum;
    bit acc;
    fill_bytes(12);
    @(negedge clk_i);
    base_addr_i = 14'h100; len_bytes_i = 16'd12; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; got = 0; cyc = 0;
    while (got < 6 && cyc < 100) begin
      s_valid_i = 1'b1; s_data_i = byte_q[got]; acc = s_ready_o;
      @(negedge clk_i);
      if (acc) got++;
      cyc++;
    end
    s_valid_i = 1'b0;
    tests++;
    if (got !== 6 || busy_o !== 1'b1) begin
      failed++;
      $display("FAIL midload_progress: got %0d bytes busy=%b, required 6 bytes busy=1", got, busy_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({s_ready_o, req_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o, checksum_o} !== '0) begin
      failed++;
      $display("FAIL midload_reset_outputs: got ready=%b req=%b busy=%b done=%b sum=%h, required all 0",
               s_ready_o, req_o, busy_o, done_o, checksum_o);
    end
    tests++;
    if (core_rst_no !== 1'b0) begin
      failed++;
      $display("FAIL midload_core_rst: got %b required 0", core_rst_no);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    run_load(32'h100, 12, 1'b0, 1'b0, lat);
    exp_sum = build_model(32'h100, 12);
    tests++;
    if (wr_log.size() !== 3 || wr_mismatches() !== 0) begin
      failed++;
      $display("FAIL restart_writes: got %0d writes %0d bad, required 3 writes 0 bad",
               wr_log.size(), wr_mismatches());
    end
    tests++;
    if (checksum_o !== exp_sum || core_rst_no !== 1'b1) begin
      failed++;
      $display("FAIL restart_result: got sum=%h core_rst_no=%b, required sum=%h core_rst_no=1",
               checksum_o, core_rst_no, exp_sum);
    end
  endtask

  task automatic test_normal();
    int unsigned lat;
    logic [31:0] exp_sum;
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(32'h010, 8, 1'b0, 1'b0, lat);
    exp_sum = build_model(32'h010, 8);
    tests++;
    if (wr_log.size() !== 2 || wr_mismatches() !== 0) begin
      failed++;
      $display("FAIL normal_writes: got %0d writes %0d bad, required 2 writes 0 bad",
               wr_log.size(), wr_mismatches());
    end
    tests++;
    if (rd_mismatches() !== 0 || rd_be_bad !== 0) begin
      failed++;
      $display("FAIL normal_reads: got %0d bad addrs %0d bad be, required 0", rd_mismatches(), rd_be_bad);
    end
    tests++;
    if (checksum_o !== 32'h0C0A0806 || checksum_o !== exp_sum) begin
      failed++;
      $display("FAIL normal_checksum: got %h required %h", checksum_o, exp_sum);
    end
    tests++;
    if (done_cnt !== 1 || lat !== 14) begin
      failed++;
      $display("FAIL normal_done: got %0d pulses latency %0d, required 1 pulse latency 14", done_cnt, lat);
    end
    tests++;
    if (core_rst_no !== 1'b1 || busy_o !== 1'b0) begin
      failed++;
      $display("FAIL normal_idle: got core_rst_no=%b busy=%b, required 1 and 0", core_rst_no, busy_o);
    end
  endtask

  task automatic test_partial();
    int unsigned lat;
    logic [31:0] exp_sum;
    byte_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    run_load(32'h021, 4, 1'b0, 1'b0, lat);
    exp_sum = build_model(32'h021, 4);
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(32'h020, 5, 1'b0, 1'b0, lat);
    exp_sum = build_model(32'h020, 5);
    tests++;
    if (wr_log.size() !== 2 || wr_mismatches() !== 0) begin
      failed++;
      $display("FAIL partial_writes: got %0d writes %0d bad, required 2 writes 0 bad",
               wr_log.size(), wr_mismatches());
    end
    tests++;
    if (wr_log.size() >= 2 && (wr_log[1].be !== 4'b0001 || wr_log[1].data[7:0] !== 8'hEE)) begin
      failed++;
      $display("FAIL partial_last_word: got be=%b data=%h, required be=0001 data[7:0]=ee",
               wr_log[1].be, wr_log[1].data);
    end
    tests++;
    if (checksum_o !== 32'hDDCCBC98 || checksum_o !== exp_sum) begin
      failed++;
      $display("FAIL partial_checksum: got %h required %h", checksum_o, exp_sum);
    end
  endtask

  task automatic test_wrap();
    int unsigned lat;
    logic [31:0] exp_sum;
    fill_bytes(8);
    run_load(MemWords - 1, 8, 1'b0, 1'b0, lat);
    exp_sum = build_model(MemWords - 1, 8);
    tests++;
    if (wr_log.size() !== 2 || wr_mismatches() !== 0 || rd_mismatches() !== 0) begin
      failed++;
      $display("FAIL wrap_addresses: got %0d writes %0d bad writes %0d bad reads, required 2/0/0",
               wr_log.size(), wr_mismatches(), rd_mismatches());
    end
    tests++;
    if (checksum_o !== exp_sum) begin
      failed++;
      $display("FAIL wrap_checksum: got %h required %h", checksum_o, exp_sum);
    end
  endtask

  task automatic test_zero_len();
    int unsigned lat;
    byte_q.delete();
    run_load(32'h200, 0, 1'b0, 1'b0, lat);
    tests++;
    if (req_cnt !== 0 || checksum_o !== 32'h0) begin
      failed++;
      $display("FAIL zero_len_traffic: got %0d requests sum=%h, required 0 and 0", req_cnt, checksum_o);
    end
    tests++;
    if (done_cnt !== 1 || lat < 1 || lat > 2) begin
      failed++;
      $display("FAIL zero_len_done: got %0d pulses latency %0d, required 1 pulse latency 1..2",
               done_cnt, lat);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lat, base, len;
    logic [31:0] exp_sum;
    for (int unsigned it = 0; it < 6; it++) begin
      base = $urandom_range(0, MemWords - 1);
      len  = $urandom_range(1, 48);
      fill_bytes(len);
      run_load(base, len, 1'b1, 1'b1, lat);
      exp_sum = build_model(base, len);
      tests++;
      if (wr_log.size() !== exp_wr.size() || wr_mismatches() !== 0 || rd_mismatches() !== 0) begin
        failed++;
        $display("FAIL b2b_traffic[%0d]: got %0d writes %0d bad writes %0d bad reads, required %0d/0/0",
                 it, wr_log.size(), wr_mismatches(), rd_mismatches(), exp_wr.size());
      end
      tests++;
      if (checksum_o !== exp_sum || done_cnt !== 1) begin
        failed++;
        $display("FAIL b2b_result[%0d]: got sum=%h done=%0d, required sum=%h done=1",
                 it, checksum_o, done_cnt, exp_sum);
      end
      tests++;
      if (wr_rdy_viol !== 0) begin
        failed++;
        $display("FAIL b2b_ready_in_write[%0d]: got %0d cycles, required 0", it, wr_rdy_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_normal();
    test_partial();
    test_wrap();
    test_zero_len();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
